instr_prefetch: RTL and testbench
=================================

# instr_prefetch

Decoupled, parametrised instruction-fetch front end: keeps up to MAX_OUTSTANDING in-order fetch requests in flight to the instruction memory path (TLB + I-cache) and buffers returned words in a QUEUE_DEPTH-entry FIFO feeding decode through a valid/ready handshake. It replaces the single-slot, stall-on-miss fetch stage with branch redirect/flush, stale-response squashing and back-pressure. Sits between the core's branch-resolution logic and decode.

## Interface
Parameters:
- ADDRESS_WIDTH, 64, PC and memory address width
- INSTRUCTION_WIDTH, 32, instruction word width
- QUEUE_DEPTH, 4, FIFO entries; power of two, ≥2
- MAX_OUTSTANDING, 2, in-flight memory requests; 1..QUEUE_DEPTH
- RESET_PC, 0, first fetch address after reset

Ports (reset is synchronous, active-high; clock is clk):
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- redirect_valid  in  1  branch taken / PC redirect this cycle
- redirect_target  in  ADDRESS_WIDTH  new PC; bits [1:0] ignored (treated as 0)
- mem_req_valid  out  1  fetch request
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDRESS_WIDTH  fetch address
- mem_resp_valid  in  1  in-order response, one per accepted request
- mem_resp_data  in  INSTRUCTION_WIDTH  instruction word
- out_valid  out  1  head entry valid
- out_ready  in  1  decode accepts head
- out_pc  out  ADDRESS_WIDTH  PC of head instruction
- out_pcplus4  out  ADDRESS_WIDTH  out_pc + 4
- out_instruction  out  INSTRUCTION_WIDTH  head instruction
- halted  out  1  fetch stopped (only meaningful with IPF_ZERO_HALT_EN)

## Operation
- fetch_pc register: next address to request; +4 (mod 2^ADDRESS_WIDTH) on each accepted request (mem_req_valid & mem_req_ready).
- Issue condition: mem_req_valid = !redirect_valid & !halted & (outstanding < MAX_OUTSTANDING) & (count + outstanding < QUEUE_DEPTH). Guarantees every live response has a free slot; no response back-pressure exists.
- Each request's PC pushed into an internal in-flight PC FIFO (depth MAX_OUTSTANDING); popped on response, paired with data into the queue.
- Redirect: queue and in-flight PC FIFO flushed, fetch_pc <= {redirect_target[AW-1:2],2'b00}, drop_cnt <= outstanding (excluding any response arriving that cycle). Subsequent responses while drop_cnt>0 are discarded and decrement drop_cnt; outstanding still decrements. New requests may issue while drop_cnt>0.
- Redirect takes priority over simultaneous out handshake, response write, and request (request suppressed).
- Queue full and out_ready same cycle with response: pop and push both occur; count unchanged.
- Empty queue: out_valid=0; outputs hold last head values (don't-care).
- States: RUN, HALTED (HALTED only with macro). reset → RUN.

## Timing
- Reset values: mem_req_valid 0 during reset, out_valid 0, halted 0, count/outstanding/drop_cnt 0, fetch_pc RESET_PC; first request first cycle after reset deasserts.
- mem_req_valid/addr are functions of registers and redirect_valid only; never depend on mem_req_ready.
- Response at cycle t → out_valid at t+1 (queue empty case). No combinational resp→out path.
- Redirect at t → request for target at t+1; with 1-cycle memory, out_valid at t+3.
- Reset mid-operation: all state cleared; responses for pre-reset requests are the memory's responsibility (memory reset together).

## Configuration
- IPF_ZERO_HALT_EN defined: a non-dropped response with all-zero data is not enqueued; block enters HALTED, halted=1, stops issuing, remaining responses dropped; queue still drains to decode. Redirect while HALTED returns to RUN and clears halted. Not defined: zero words are ordinary instructions; halted tied 0.

## Structure
- Package ipf_pkg: queue entry struct (pc, instruction), state enum, alignment constant (4).
- Sub-module ipf_fifo: parametrised sync FIFO (width, depth), used for both the instruction queue and the in-flight PC FIFO.

## Test plan
- Reset, memory 1-cycle, out_ready=1: requests at 0,4,8,…; out_pc 0,4,8 with matching words, out_pcplus4 = pc+4.
- out_ready=0, 3-cycle memory: exactly QUEUE_DEPTH(4) words buffered, mem_req_valid then 0; release → all four delivered in order, fetch resumes at 0x10.
- Two requests outstanding (0x8,0xC), redirect to 0x103: both responses dropped, next out_pc=0x100.
- Redirect same cycle as out handshake and response: nothing delivered that cycle, queue empty next cycle, request at target next cycle.
- mem_req_ready stalled 5 cycles: mem_req_addr stable, no duplicate PCs.
- With IPF_ZERO_HALT_EN: word at 0x10 = 0 → words 0x0–0xC delivered, halted=1, no further requests; redirect to 0x40 resumes.

Source files
------------

// File: rtl/ipf_pkg.sv
// Shared types for the instruction prefetch front end: queue entry layout, fetch state, fetch alignment.
package ipf_pkg;

  localparam int IPF_ALIGN  = 4;
  // Queue entries are sized for the widest supported PC and instruction word.
  localparam int IPF_MAX_AW = 64;
  localparam int IPF_MAX_IW = 32;

  typedef enum logic {
    RUN,
    HALTED
  } ipf_state_e;

  typedef struct packed {
    logic [IPF_MAX_AW-1:0] pc;
    logic [IPF_MAX_IW-1:0] instruction;
  } ipf_entry_t;

endpackage

// File: rtl/ipf_fifo.sv
// Synchronous FIFO with flush; push and pop may happen together even when full.
module ipf_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty     = (count == '0);
  assign full      = (count == CW'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_prefetch.sv
// Decoupled instruction fetch: in-order requests, response queue, redirect flush and stale-response dropping.
// Optional IPF_ZERO_HALT_EN: an all-zero fetched word stops fetching until the next redirect.
module instr_prefetch
  import ipf_pkg::*;
#(
  parameter int ADDRESS_WIDTH     = 64,
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int QUEUE_DEPTH       = 4,
  parameter int MAX_OUTSTANDING   = 2,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0]     redirect_target,
  output logic                         mem_req_valid,
  input  logic                         mem_req_ready,
  output logic [ADDRESS_WIDTH-1:0]     mem_req_addr,
  input  logic                         mem_resp_valid,
  input  logic [INSTRUCTION_WIDTH-1:0] mem_resp_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [ADDRESS_WIDTH-1:0]     out_pc,
  output logic [ADDRESS_WIDTH-1:0]     out_pcplus4,
  output logic [INSTRUCTION_WIDTH-1:0] out_instruction,
  output logic                         halted
);

  localparam int QCW = $clog2(QUEUE_DEPTH + 1);
  localparam int OCW = $clog2(MAX_OUTSTANDING + 1);

  ipf_state_e               state, state_next;
  logic [ADDRESS_WIDTH-1:0] fetch_pc;
  logic [OCW-1:0]           outstanding, outstanding_next, drop_cnt;
  logic [QCW-1:0]           q_count;
  logic                     q_empty, q_full, q_push, q_pop;
  logic [OCW-1:0]           pcf_count;
  logic                     pcf_empty, pcf_full;
  logic [ADDRESS_WIDTH-1:0] resp_pc;
  logic                     accept, resp_live, resp_zero, halt_now;
  ipf_entry_t               q_in, q_head;
  logic                     unused_flags;

  // Reserving a queue slot per in-flight request means responses never need back-pressure.
  assign mem_req_valid = !reset && !redirect_valid && (state == RUN)
                         && (outstanding < OCW'(MAX_OUTSTANDING))
                         && (int'(q_count) + int'(outstanding) < QUEUE_DEPTH);
  assign mem_req_addr     = fetch_pc;
  assign accept           = mem_req_valid && mem_req_ready;
  assign outstanding_next = outstanding + OCW'(accept) - OCW'(mem_resp_valid);
  assign resp_live        = mem_resp_valid && (drop_cnt == '0) && !redirect_valid && (state == RUN);

`ifdef IPF_ZERO_HALT_EN
  assign resp_zero = resp_live && (mem_resp_data == '0);
  assign halted    = (state == HALTED);
`else
  assign resp_zero = 1'b0;
  assign halted    = 1'b0;
`endif

  assign halt_now = resp_zero;
  assign q_push   = resp_live && !resp_zero;
  assign q_pop    = out_valid && out_ready && !redirect_valid;

  assign q_in.pc          = IPF_MAX_AW'(resp_pc);
  assign q_in.instruction = IPF_MAX_IW'(mem_resp_data);

  assign out_valid       = !q_empty;
  assign out_pc          = q_head.pc[ADDRESS_WIDTH-1:0];
  assign out_instruction = q_head.instruction[INSTRUCTION_WIDTH-1:0];
  assign out_pcplus4     = out_pc + ADDRESS_WIDTH'(IPF_ALIGN);

  assign unused_flags = ^{pcf_count, pcf_empty, pcf_full, q_full, redirect_target[1:0]};

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (redirect_valid) state_next = RUN;
    else if (halt_now)  state_next = HALTED;
  end

  // Everything in flight when fetch is redirected or halted is stale and must be discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect_valid) fetch_pc <= {redirect_target[ADDRESS_WIDTH-1:2], 2'b00};
      else if (accept)    fetch_pc <= fetch_pc + ADDRESS_WIDTH'(IPF_ALIGN);
      if (redirect_valid || halt_now)           drop_cnt <= outstanding_next;
      else if (mem_resp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
    end
  end

  ipf_fifo #(.WIDTH(ADDRESS_WIDTH), .DEPTH(MAX_OUTSTANDING)) u_pc_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid || halt_now),
    .push      (accept),
    .push_data (fetch_pc),
    .pop       (resp_live),
    .head_data (resp_pc),
    .count     (pcf_count),
    .empty     (pcf_empty),
    .full      (pcf_full)
  );

  ipf_fifo #(.WIDTH($bits(ipf_entry_t)), .DEPTH(QUEUE_DEPTH)) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (q_push),
    .push_data (q_in),
    .pop       (q_pop),
    .head_data (q_head),
    .count     (q_count),
    .empty     (q_empty),
    .full      (q_full)
  );

endmodule

// File: tb/tb_instr_prefetch.sv
// Self-checking bench for instr_prefetch: table-driven startup, directed corner cases, randomized stream scoreboard.
module tb_instr_prefetch;

  localparam int AW = 64;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_target = '0;
  logic          mem_req_valid;
  logic          mem_req_ready = 1'b1;
  logic [AW-1:0] mem_req_addr;
  logic          mem_resp_valid = 1'b0;
  logic [IW-1:0] mem_resp_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [AW-1:0] out_pc, out_pcplus4;
  logic [IW-1:0] out_instruction;
  logic          halted;

  int            total = 0;
  int            bad = 0;
  int            delivered = 0;
  int            cyc = 0;
  int            mem_lat = 1;
  logic [AW-1:0] exp_req = '0;
  logic [AW-1:0] exp_out = '0;
  logic [AW-1:0] zero_addr = '1;

  typedef struct {
    logic [AW-1:0] addr;
    int            due;
  } pend_t;
  pend_t         pend[$];
  bit            acc_seen = 1'b0;
  logic [AW-1:0] acc_addr = '0;

  typedef struct {
    logic          req_v;
    logic [AW-1:0] req_addr;
    logic          out_v;
    logic [AW-1:0] pc;
  } vec_t;
  vec_t vecs[6];

  instr_prefetch dut (
    .clk             (clk),
    .reset           (reset),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_addr    (mem_req_addr),
    .mem_resp_valid  (mem_resp_valid),
    .mem_resp_data   (mem_resp_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_pcplus4     (out_pcplus4),
    .out_instruction (out_instruction),
    .halted          (halted)
  );

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] word_at(input logic [AW-1:0] a);
    if (a == zero_addr) return '0;
    return a[IW-1:0] ^ 32'hC0DE_0001;
  endfunction

  task automatic checkOutput(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    exp_req = '0;
    exp_out = '0;
  endtask

  // Memory model: in-order responses, each no earlier than mem_lat cycles after acceptance.
  always @(negedge clk) begin
    acc_seen = mem_req_valid && mem_req_ready;
    acc_addr = mem_req_addr;
  end

  always @(posedge clk) begin
    bit r;
    r = reset;
    if (r) pend.delete();
    else begin
      if (mem_resp_valid && pend.size() > 0) void'(pend.pop_front());
      if (acc_seen) pend.push_back('{acc_addr, cyc + mem_lat});
    end
    cyc++;
    #1;
    if (!r && pend.size() > 0 && pend[0].due <= cyc) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = word_at(pend[0].addr);
    end else begin
      mem_resp_valid = 1'b0;
    end
  end

  // Stream scoreboard: after any redirect, requests and deliveries must walk target, target+4, ...
  always @(negedge clk) begin
    if (!reset) begin
      checkOutput("inflight_le_max", 64'(pend.size() <= 2), 64'd1);
      if (redirect_valid) begin
        checkOutput("req_suppressed_on_redirect", 64'(mem_req_valid), 64'd0);
        exp_req = {redirect_target[AW-1:2], 2'b00};
        exp_out = {redirect_target[AW-1:2], 2'b00};
      end else begin
        if (mem_req_valid && mem_req_ready) begin
          checkOutput("req_addr", mem_req_addr, exp_req);
          exp_req = exp_req + 64'd4;
        end
        if (out_valid && out_ready) begin
          checkOutput("out_pc", out_pc, exp_out);
          checkOutput("out_pcplus4", out_pcplus4, exp_out + 64'd4);
          checkOutput("out_instr", 64'(out_instruction), 64'(word_at(exp_out)));
          exp_out = exp_out + 64'd4;
          delivered++;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int  d0;
    bit  found;
    bit  got;

    vecs[0] = '{1'b1, 64'h0,  1'b0, 64'h0};
    vecs[1] = '{1'b1, 64'h4,  1'b0, 64'h0};
    vecs[2] = '{1'b1, 64'h8,  1'b1, 64'h0};
    vecs[3] = '{1'b1, 64'hC,  1'b1, 64'h4};
    vecs[4] = '{1'b1, 64'h10, 1'b1, 64'h8};
    vecs[5] = '{1'b1, 64'h14, 1'b1, 64'hC};

    // Reset state and 1-cycle memory streaming
    repeat (2) applyStimulus();
    @(negedge clk);
    checkOutput("rst_req_valid", 64'(mem_req_valid), 64'd0);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_halted", 64'(halted), 64'd0);
    mem_lat = 1;
    out_ready = 1'b1;
    doReset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput($sformatf("t1_req_valid[%0d]", i), 64'(mem_req_valid), 64'(vecs[i].req_v));
      checkOutput($sformatf("t1_req_addr[%0d]", i), mem_req_addr, vecs[i].req_addr);
      checkOutput($sformatf("t1_out_valid[%0d]", i), 64'(out_valid), 64'(vecs[i].out_v));
      if (vecs[i].out_v) begin
        checkOutput($sformatf("t1_out_pc[%0d]", i), out_pc, vecs[i].pc);
        checkOutput($sformatf("t1_out_instr[%0d]", i), 64'(out_instruction), 64'(word_at(vecs[i].pc)));
      end
      applyStimulus();
    end

    // Back-pressure: queue fills to exactly four entries, then drains in order
    out_ready = 1'b0;
    mem_lat = 3;
    doReset();
    repeat (20) applyStimulus();
    @(negedge clk);
    checkOutput("t2_req_stopped", 64'(mem_req_valid), 64'd0);
    checkOutput("t2_out_valid", 64'(out_valid), 64'd1);
    checkOutput("t2_head_pc", out_pc, 64'h0);
    checkOutput("t2_no_inflight", 64'(pend.size()), 64'd0);
    applyStimulus();
    out_ready = 1'b1;
    d0 = delivered;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput($sformatf("t2_drain_valid[%0d]", i), 64'(out_valid), 64'd1);
      applyStimulus();
    end
    @(negedge clk);
    checkOutput("t2_exactly_four", 64'(out_valid), 64'd0);
    checkOutput("t2_four_delivered", 64'(delivered - d0), 64'd4);
    repeat (12) applyStimulus();
    checkOutput("t2_resumed", 64'(delivered > d0 + 4), 64'd1);

    // Redirect with two requests in flight: both responses dropped
    mem_lat = 3;
    out_ready = 1'b1;
    doReset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (pend.size() == 2 && pend[0].addr == 64'h8 && pend[1].addr == 64'hC) found = 1'b1;
      else applyStimulus();
    end
    checkOutput("t3_two_inflight", 64'(found), 64'd1);
    applyStimulus();
    redirect_valid = 1'b1;
    redirect_target = 64'h103;
    applyStimulus();
    redirect_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        got = 1'b1;
        checkOutput("t3_first_pc", out_pc, 64'h100);
      end
      applyStimulus();
    end
    checkOutput("t3_delivered", 64'(got), 64'd1);

    // Redirect coinciding with out handshake and response
    mem_lat = 1;
    doReset();
    repeat (6) applyStimulus();
    redirect_valid = 1'b1;
    redirect_target = 64'h200;
    @(negedge clk);
    checkOutput("t4_pre_out_valid", 64'(out_valid), 64'd1);
    applyStimulus();
    redirect_valid = 1'b0;
    @(negedge clk);
    checkOutput("t4_q_empty", 64'(out_valid), 64'd0);
    checkOutput("t4_req_valid", 64'(mem_req_valid), 64'd1);
    checkOutput("t4_req_addr", mem_req_addr, 64'h200);
    applyStimulus();
    @(negedge clk);
    checkOutput("t4_still_empty", 64'(out_valid), 64'd0);
    applyStimulus();
    @(negedge clk);
    checkOutput("t4_out_valid", 64'(out_valid), 64'd1);
    checkOutput("t4_out_pc", out_pc, 64'h200);
    applyStimulus();

    // Request channel stalled for five cycles
    doReset();
    repeat (4) applyStimulus();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput($sformatf("t5_stall_valid[%0d]", i), 64'(mem_req_valid), 64'd1);
      checkOutput($sformatf("t5_stall_addr[%0d]", i), mem_req_addr, exp_req);
      applyStimulus();
    end
    mem_req_ready = 1'b1;
    d0 = delivered;
    repeat (8) applyStimulus();
    checkOutput("t5_resumed", 64'(delivered > d0), 64'd1);

    // Randomized traffic against the stream scoreboard
    doReset();
    d0 = delivered;
    for (int seg = 0; seg < 6; seg++) begin
      mem_lat = $urandom_range(1, 4);
      for (int c = 0; c < 100; c++) begin
        applyStimulus();
        out_ready       = ($urandom_range(0, 3) != 0);
        mem_req_ready   = ($urandom_range(0, 3) != 0);
        redirect_valid  = ($urandom_range(0, 19) == 0);
        redirect_target = {$urandom, $urandom};
      end
    end
    applyStimulus();
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    mem_req_ready = 1'b1;
    repeat (20) applyStimulus();
    checkOutput("rand_progress", 64'(delivered >= d0 + 30), 64'd1);

`ifdef IPF_ZERO_HALT_EN
    // Zero word at 0x10 halts fetch; redirect resumes
    mem_lat = 1;
    zero_addr = 64'h10;
    doReset();
    d0 = delivered;
    repeat (12) applyStimulus();
    @(negedge clk);
    checkOutput("halt_halted", 64'(halted), 64'd1);
    checkOutput("halt_no_req", 64'(mem_req_valid), 64'd0);
    checkOutput("halt_q_empty", 64'(out_valid), 64'd0);
    checkOutput("halt_four_words", 64'(delivered - d0), 64'd4);
    applyStimulus();
    zero_addr = '1;
    redirect_valid = 1'b1;
    redirect_target = 64'h40;
    applyStimulus();
    redirect_valid = 1'b0;
    @(negedge clk);
    checkOutput("halt_cleared", 64'(halted), 64'd0);
    checkOutput("halt_resume_addr", mem_req_addr, 64'h40);
    d0 = delivered;
    repeat (6) applyStimulus();
    checkOutput("halt_resume_delivery", 64'(delivered > d0), 64'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
